// File: rtl/apu_pkg.sv
// Shared definitions for the APU frame sequencer: default step timing,
// frame-mode and write-pipeline enums, and $4017 bit positions.
package apu_pkg;

  localparam int unsigned STEP1_DEF    = 7457;
  localparam int unsigned STEP2_DEF    = 14913;
  localparam int unsigned STEP3_DEF    = 22371;
  localparam int unsigned STEP4_DEF    = 29829;
  localparam int unsigned STEP5_DEF    = 37281;
  localparam int unsigned WR_DELAY_DEF = 3;
  localparam int unsigned CNT_W_DEF    = 16;

  localparam int unsigned FC_MODE_BIT    = 7;
  localparam int unsigned FC_IRQ_INH_BIT = 6;

  typedef enum logic {
    FOUR_STEP = 1'b0,
    FIVE_STEP = 1'b1
  } frame_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } wr_state_e;

  // Steps must be strictly increasing and representable in the counter width.
  function automatic bit steps_ok(input int unsigned s1, input int unsigned s2,
                                  input int unsigned s3, input int unsigned s4,
                                  input int unsigned s5, input int unsigned w);
    longint unsigned lim;
    lim = (w >= 32) ? 64'h1_0000_0000 : (64'd1 << w);
    return (s1 < s2) && (s2 < s3) && (s3 < s4) && (s4 < s5) &&
           (longint'(s5) < lim);
  endfunction

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// CPU-register and channel-strobe bundle of the frame sequencer, plus
// debug visibility of the frame counter and write-pipeline state.
interface apu_frame_sequencer_if
  import apu_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  // Protocol: fc_wr and status_rd are single-cycle strobes with no ready;
  // fc_wdata is only meaningful while fc_wr is high. quarter_frame and
  // half_frame are single-cycle pulses, frame_irq and mode are levels.
  logic             fc_wr;
  logic [7:0]       fc_wdata;
  logic             status_rd;
  logic             quarter_frame;
  logic             half_frame;
  logic             frame_irq;
  logic             mode;
  logic [CNT_W-1:0] frame_cnt;
  wr_state_e        wr_state;

  modport master (
    output fc_wr,
    output fc_wdata,
    output status_rd,
    input  quarter_frame,
    input  half_frame,
    input  frame_irq,
    input  mode,
    input  frame_cnt,
    input  wr_state
  );

  modport slave (
    input  fc_wr,
    input  fc_wdata,
    input  status_rd,
    output quarter_frame,
    output half_frame,
    output frame_irq,
    output mode,
    output frame_cnt,
    output wr_state
  );

endinterface

// File: rtl/apu_frame_sequencer_fc_write_delay.sv
// $4017 write pipeline: latches the requested mode and counts down the
// write delay, then emits a one-cycle apply strobe with the new mode.
module fc_write_delay
  import apu_pkg::*;
#(
  parameter int unsigned WR_DELAY = WR_DELAY_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic        wr_mode,
  output logic        apply,
  output frame_mode_e new_mode,
  output wr_state_e   state
);

  localparam int unsigned DLY_W = (WR_DELAY < 3) ? 2 : $clog2(WR_DELAY + 1);
  localparam bit          SHORT = (WR_DELAY <= 1);

  logic [DLY_W-1:0] delay;

  // apply is raised on the transition into APPLY so the top acts on it at
  // exactly WR_DELAY edges after the write; a new write always restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      delay    <= '0;
      apply    <= 1'b0;
      new_mode <= FOUR_STEP;
    end else begin
      apply <= 1'b0;
      if (wr) begin
        new_mode <= frame_mode_e'(wr_mode);
        delay    <= DLY_W'(WR_DELAY);
        if (SHORT) begin
          state <= APPLY;
          apply <= 1'b1;
        end else begin
          state <= PEND;
        end
      end else begin
        case (state)
          PEND: begin
            delay <= delay - DLY_W'(1);
            if (delay == DLY_W'(2)) begin
              state <= APPLY;
              apply <= 1'b1;
            end
          end
          APPLY: begin
            state <= IDLE;
            delay <= '0;
          end
          default: begin
            state <= IDLE;
            delay <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: quarter/half-frame strobes, 4/5-step modes, frame IRQ.
// Build option: define FRAME_SEQ_IRQ_EN to implement the frame IRQ logic.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned STEP1    = STEP1_DEF,
  parameter int unsigned STEP2    = STEP2_DEF,
  parameter int unsigned STEP3    = STEP3_DEF,
  parameter int unsigned STEP4    = STEP4_DEF,
  parameter int unsigned STEP5    = STEP5_DEF,
  parameter int unsigned WR_DELAY = WR_DELAY_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  apu_frame_sequencer_if.slave bus
);

  if (!steps_ok(STEP1, STEP2, STEP3, STEP4, STEP5, CNT_W) || (WR_DELAY < 1))
  begin : g_cfg_check
    $error("apu_frame_sequencer: steps must increase strictly and fit CNT_W; WR_DELAY >= 1");
  end

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

  logic [CNT_W-1:0] cnt;
  frame_mode_e      mode_q;
  logic             quarter_q;
  logic             half_q;
  logic             step_q;
  logic             step_h;
  logic             wrap;
  logic             apply;
  frame_mode_e      new_mode;
  wr_state_e        wr_state;

  fc_write_delay #(
    .WR_DELAY (WR_DELAY)
  ) u_wr_delay (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (bus.fc_wr),
    .wr_mode  (bus.fc_wdata[FC_MODE_BIT]),
    .apply    (apply),
    .new_mode (new_mode),
    .state    (wr_state)
  );

  always_comb begin
    step_q = 1'b0;
    step_h = 1'b0;
    wrap   = 1'b0;
    if (cnt == S1 || cnt == S3) begin
      step_q = 1'b1;
    end
    if (cnt == S2) begin
      step_q = 1'b1;
      step_h = 1'b1;
    end
    if (cnt == S4 && mode_q == FOUR_STEP) begin
      step_q = 1'b1;
      step_h = 1'b1;
      wrap   = 1'b1;
    end
    if (cnt == S5 && mode_q == FIVE_STEP) begin
      step_q = 1'b1;
      step_h = 1'b1;
      wrap   = 1'b1;
    end
  end

  // An apply overrides any step match in the same cycle, so the strobes
  // carry at most one pulse pair: the one implied by the new mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      mode_q    <= FOUR_STEP;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
    end else if (apply) begin
      cnt       <= '0;
      mode_q    <= new_mode;
      quarter_q <= (new_mode == FIVE_STEP);
      half_q    <= (new_mode == FIVE_STEP);
    end else begin
      cnt       <= wrap ? '0 : cnt + CNT_W'(1);
      quarter_q <= step_q;
      half_q    <= step_h;
    end
  end

`ifdef FRAME_SEQ_IRQ_EN
  logic irq_q;
  logic irq_inhibit;
  logic irq_hit;
  logic irq_clr;
  logic unused_wdata;

  assign irq_hit      = (cnt == S4) && (mode_q == FOUR_STEP) && !irq_inhibit;
  assign irq_clr      = bus.status_rd || (bus.fc_wr && bus.fc_wdata[FC_IRQ_INH_BIT]);
  assign unused_wdata = ^bus.fc_wdata[5:0];

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q       <= 1'b0;
      irq_inhibit <= 1'b0;
    end else begin
      if (bus.fc_wr) begin
        irq_inhibit <= bus.fc_wdata[FC_IRQ_INH_BIT];
      end
      if (irq_hit) begin
        irq_q <= 1'b1;
      end else if (irq_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign bus.frame_irq = irq_q;
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{bus.fc_wdata[FC_IRQ_INH_BIT], bus.fc_wdata[5:0], bus.status_rd};
  assign bus.frame_irq     = 1'b0;
`endif

  assign bus.quarter_frame = quarter_q;
  assign bus.half_frame    = half_q;
  assign bus.mode          = mode_q;
  assign bus.frame_cnt     = cnt;
  assign bus.wr_state      = wr_state;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer with shortened step timing; pulse events are
// scoreboarded by cycle number, levels are checked at chosen cycles.
module tb_apu_frame_sequencer;
  import apu_pkg::*;

  localparam int unsigned S1 = 20;
  localparam int unsigned S2 = 41;
  localparam int unsigned S3 = 62;
  localparam int unsigned S4 = 83;
  localparam int unsigned S5 = 104;
  localparam int unsigned WD = 3;
  localparam int unsigned CW = 16;
  localparam int W = 34;
`ifdef FRAME_SEQ_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];

  apu_frame_sequencer_if #(.CNT_W(CW)) bus ();

  apu_frame_sequencer #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5),
    .WR_DELAY(WD), .CNT_W(CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: cyc=%0d required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // scoreboard: entries are {cycle, quarter, half}
  task automatic expect_pulse(input int unsigned t, input logic q, input logic h);
    exp_q.push_back({t, q, h});
  endtask

  always @(negedge clk) begin
    if (reset_n && (bus.quarter_frame || bus.half_frame)) begin
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", {cyc, bus.quarter_frame, bus.half_frame}, '0);
      end else begin
        check("pulse", {cyc, bus.quarter_frame, bus.half_frame}, exp_q.pop_front());
      end
    end
  end

  task automatic drain(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // drivers
  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset(output int unsigned base);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base = cyc;
    exp_q.delete();
  endtask

  task automatic cpu_write(input logic [7:0] d, output int unsigned w);
    w = cyc + 1;
    bus.fc_wr    = 1'b1;
    bus.fc_wdata = d;
    @(negedge clk);
    bus.fc_wr    = 1'b0;
  endtask

  task automatic landing(input logic [7:0] d, input string tag);
    int unsigned r, w, a;
    do_reset(r);
    a = r + S2 + 1;
    expect_pulse(r + S1 + 1, 1'b1, 1'b0);
    wait_until(a - 4);
    cpu_write(d, w);
    if (d[7]) expect_pulse(a, 1'b1, 1'b1);
    expect_pulse(a + S1 + 1, 1'b1, 1'b0);
    expect_pulse(a + S2 + 1, 1'b1, 1'b1);
    wait_until(a);
    check({tag, "_cnt0"}, bus.frame_cnt, 0);
    check({tag, "_mode"}, bus.mode, d[7]);
    wait_until(a + S2 + 3);
    drain({tag, "_drain"});
  endtask

  initial begin
    int unsigned r, w, w2, a;
    bus.fc_wr     = 1'b0;
    bus.fc_wdata  = '0;
    bus.status_rd = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_quarter", bus.quarter_frame, 0);
    check("rst_half", bus.half_frame, 0);
    check("rst_irq", bus.frame_irq, 0);
    check("rst_mode", bus.mode, 0);
    check("rst_cnt", bus.frame_cnt, 0);

    // 1: free-running 4-step frame
    do_reset(r);
    expect_pulse(r + S1 + 1, 1'b1, 1'b0);
    expect_pulse(r + S2 + 1, 1'b1, 1'b1);
    expect_pulse(r + S3 + 1, 1'b1, 1'b0);
    expect_pulse(r + S4 + 1, 1'b1, 1'b1);
    expect_pulse(r + S4 + 1 + S1 + 1, 1'b1, 1'b0);
    wait_until(r + S4);
    check("s1_irq_pre", bus.frame_irq, 0);
    wait_until(r + S4 + 1);
    check("s1_irq_set", bus.frame_irq, IRQ_EXP);
    check("s1_mode", bus.mode, 0);
    wait_until(r + S4 + S1 + 4);
    check("s1_irq_hold", bus.frame_irq, IRQ_EXP);
    drain("s1_drain");

    // 2a: status read clears the flag
    bus.status_rd = 1'b1;
    @(negedge clk);
    bus.status_rd = 1'b0;
    check("s2_rd_clr", bus.frame_irq, 0);

    // 2b: inhibit write clears the flag and blocks the next set
    do_reset(r);
    expect_pulse(r + S1 + 1, 1'b1, 1'b0);
    expect_pulse(r + S2 + 1, 1'b1, 1'b1);
    expect_pulse(r + S3 + 1, 1'b1, 1'b0);
    expect_pulse(r + S4 + 1, 1'b1, 1'b1);
    wait_until(r + S4 + 1);
    check("s2_irq_set", bus.frame_irq, IRQ_EXP);
    cpu_write(8'h40, w);
    check("s2_wr_clr", bus.frame_irq, 0);
    a = w + WD;
    expect_pulse(a + S1 + 1, 1'b1, 1'b0);
    expect_pulse(a + S2 + 1, 1'b1, 1'b1);
    expect_pulse(a + S3 + 1, 1'b1, 1'b0);
    expect_pulse(a + S4 + 1, 1'b1, 1'b1);
    wait_until(a);
    check("s2_cnt0", bus.frame_cnt, 0);
    wait_until(a + S4 + 1);
    check("s2_irq_inh", bus.frame_irq, 0);
    wait_until(a + S4 + 3);
    drain("s2_drain");

    // 3: switch to 5-step
    do_reset(r);
    wait_until(r + 5);
    cpu_write(8'h80, w);
    check("s3_state_pend", bus.wr_state, PEND);
    a = w + WD;
    expect_pulse(a, 1'b1, 1'b1);
    expect_pulse(a + S1 + 1, 1'b1, 1'b0);
    expect_pulse(a + S2 + 1, 1'b1, 1'b1);
    expect_pulse(a + S3 + 1, 1'b1, 1'b0);
    expect_pulse(a + S5 + 1, 1'b1, 1'b1);
    expect_pulse(a + S5 + 1 + S1 + 1, 1'b1, 1'b0);
    wait_until(a - 1);
    check("s3_mode_pre", bus.mode, 0);
    wait_until(a);
    check("s3_mode", bus.mode, 1);
    check("s3_cnt0", bus.frame_cnt, 0);
    wait_until(a + S4 + 1);
    check("s3_irq", bus.frame_irq, 0);
    wait_until(a + S5 + S1 + 4);
    check("s3_state_idle", bus.wr_state, IDLE);
    drain("s3_drain");

    // 4: back-to-back writes, last one wins
    do_reset(r);
    wait_until(r + 5);
    cpu_write(8'h80, w);
    cpu_write(8'h00, w2);
    a = w2 + WD;
    expect_pulse(a + S1 + 1, 1'b1, 1'b0);
    expect_pulse(a + S2 + 1, 1'b1, 1'b1);
    wait_until(w + WD);
    check("s4_no_early", bus.mode, 0);
    wait_until(a);
    check("s4_cnt0", bus.frame_cnt, 0);
    check("s4_mode", bus.mode, 0);
    wait_until(a + S2 + 3);
    drain("s4_drain");

    // 5: apply coinciding with STEP2
    landing(8'h80, "s5_five");
    landing(8'h00, "s5_four");

    // 6: reset mid-delay discards the pending write
    do_reset(r);
    wait_until(r + 2);
    cpu_write(8'h80, w);
    expect_pulse(w + WD, 1'b1, 1'b1);
    wait_until(w + WD + 1);
    cpu_write(8'h80, w2);
    check("s6_mode_pre", bus.mode, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("s6_async_mode", bus.mode, 0);
    check("s6_async_cnt", bus.frame_cnt, 0);
    check("s6_async_q", bus.quarter_frame, 0);
    @(negedge clk);
    reset_n = 1'b1;
    r = cyc;
    drain("s6_pre_drain");
    expect_pulse(r + S1 + 1, 1'b1, 1'b0);
    wait_until(r + S1 + 3);
    check("s6_mode_post", bus.mode, 0);
    check("s6_irq", bus.frame_irq, 0);
    drain("s6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
